keypad_scanner: RTL and testbench

Matrix-keypad scan engine for a 4x4 keypad: drives the columns one at a time, samples the rows, debounces each press and release, and produces a 4-bit key code with a press interrupt. It sits directly upstream of the Wishbone keypad peripheral, which reads `key_code` as its data register and forwards `interrupt` to the LM32 interrupt controller.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_row_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan engine.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   localparam int KP_ROWS   = 4;
   localparam int KP_COLS   = 4;
   localparam int KP_CODE_W = 4;
   localparam int KP_IDX_W  = 2;

   localparam logic [KP_ROWS-1:0] ROW_IDLE = 4'hF;

   // Index of the lowest row line pulled low; 0 when no line is low.
   function automatic logic [KP_IDX_W-1:0] lowest_low_row(input logic [KP_ROWS-1:0] pat);
      logic [KP_IDX_W-1:0] idx;
      idx = '0;
      for (int i = KP_ROWS - 1; i >= 0; i--) begin
         if (!pat[i]) idx = KP_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_row_sync
   import keypad_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [KP_ROWS-1:0] i_row,
   output logic [KP_ROWS-1:0] o_row
);

   logic [KP_ROWS-1:0] r_meta;
   logic [KP_ROWS-1:0] r_sync;

   // Resets to the idle (all released) pattern so no phantom press is seen.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_meta <= ROW_IDLE;
         r_sync <= ROW_IDLE;
      end else begin
         r_meta <= i_row;
         r_sync <= r_meta;
      end
   end

   assign o_row = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan engine: column drive, slot divider, debounce FSM, key outputs.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [KP_ROWS-1:0]   row,
   output logic [KP_COLS-1:0]   column,
   output logic [KP_CODE_W-1:0] key_code,
   output logic                 key_valid,
   output logic                 key_down,
   output logic                 interrupt,
   input  logic                 int_ack
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DBC_W-1:0] DBC_MAX  = DBC_W'(DEBOUNCE_CNT);
   localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

   // Debounce counter increment that sticks at its terminal value.
   function automatic logic [DBC_W-1:0] sat_inc(input logic [DBC_W-1:0] cnt);
      return (cnt == DBC_MAX) ? cnt : cnt + DBC_ONE;
   endfunction

   logic [KP_ROWS-1:0]   w_row;
   logic                 w_sample;
   kp_state_t            r_state, w_state_nx;
   logic [DIV_W-1:0]     r_div;
   logic [DBC_W-1:0]     r_cnt, w_cnt_nx;
   logic [KP_IDX_W-1:0]  r_col, w_col_nx;
   logic [KP_IDX_W-1:0]  r_cand_row, w_cand_row_nx;
   logic [KP_ROWS-1:0]   r_cand_pat, w_cand_pat_nx;
   logic                 w_accept;
   logic                 w_release;
   logic [KP_CODE_W-1:0] r_code;
   logic                 r_valid;
   logic                 r_down;
   logic                 r_int;

   keypad_row_sync u_row_sync (
      .clk   (clk),
      .reset (reset),
      .i_row (row),
      .o_row (w_row)
   );

   assign w_sample = (r_div == DIV_LAST);

   // Free-running slot divider; rows are only looked at on its last count.
   always_ff @(posedge clk) begin
      if (!reset) r_div <= '0;
      else if (w_sample) r_div <= '0;
      else r_div <= r_div + DIV_W'(1);
   end

   // State, column index, debounce count and captured candidate.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= SCAN;
         r_cnt      <= '0;
         r_col      <= '0;
         r_cand_row <= '0;
         r_cand_pat <= ROW_IDLE;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_col      <= w_col_nx;
         r_cand_row <= w_cand_row_nx;
         r_cand_pat <= w_cand_pat_nx;
      end
   end

   // Next-state logic; everything only moves on a sample point.
   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_col_nx      = r_col;
      w_cand_row_nx = r_cand_row;
      w_cand_pat_nx = r_cand_pat;
      w_accept      = 1'b0;
      w_release     = 1'b0;
      if (w_sample) begin
         unique case (r_state)
            SCAN: begin
               if (w_row == ROW_IDLE) begin
                  w_col_nx = r_col + KP_IDX_W'(1);
               end else begin
                  w_cand_row_nx = lowest_low_row(w_row);
                  w_cand_pat_nx = w_row;
                  w_cnt_nx      = DBC_ONE;
                  w_state_nx    = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (w_row == r_cand_pat) begin
                  w_cnt_nx = sat_inc(r_cnt);
                  if (sat_inc(r_cnt) == DBC_MAX) begin
                     w_accept   = 1'b1;
                     w_state_nx = HELD;
                  end
               end else begin
                  w_state_nx = SCAN;
                  w_col_nx   = r_col + KP_IDX_W'(1);
               end
            end
            HELD: begin
               if (w_row == ROW_IDLE) begin
                  w_cnt_nx   = DBC_ONE;
                  w_state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (w_row == ROW_IDLE) begin
                  w_cnt_nx = sat_inc(r_cnt);
                  if (sat_inc(r_cnt) == DBC_MAX) begin
                     w_release  = 1'b1;
                     w_state_nx = SCAN;
                     w_col_nx   = r_col + KP_IDX_W'(1);
                  end
               end else begin
                  w_state_nx = HELD;
               end
            end
            default: w_state_nx = SCAN;
         endcase
      end
   end

   // Key outputs; an accepted press beats a simultaneous interrupt acknowledge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_code  <= '0;
         r_valid <= 1'b0;
         r_down  <= 1'b0;
         r_int   <= 1'b0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) r_code <= {r_cand_row, r_col};
         if (w_accept) r_down <= 1'b1;
         else if (w_release) r_down <= 1'b0;
         if (w_accept) r_int <= 1'b1;
         else if (int_ack) r_int <= 1'b0;
      end
   end

   assign column    = ~(4'b0001 << r_col);
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_down  = r_down;
   assign interrupt = r_int;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix feeds the rows,
// and an event-level reference model predicts every output each cycle.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DC = 3;

   logic       clk;
   logic       reset;
   logic [3:0] row;
   logic [3:0] column;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       interrupt;
   logic       int_ack;

   logic [15:0] keys;
   logic [3:0]  glitch;
   logic [3:0]  rr;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 0;

   // reference model state
   logic [3:0] m_h0, m_h1, m_cand, m_code, exp_col;
   int  m_tick, m_col, m_prun, m_rrun;
   bit  m_valid, m_down, m_int;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .column    (column),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .interrupt (interrupt),
      .int_ack   (int_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      rr = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !column[c]) rr[r] = 1'b0;
      row = rr & ~glitch;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int low_zero(input logic [3:0] p);
      int r;
      r = 0;
      for (int i = 3; i >= 0; i--) if (!p[i]) r = i;
      return r;
   endfunction

   // Reference model, advanced once per rising edge using pre-edge inputs.
   task automatic model_step();
      logic [3:0] s;
      bit smp, acc;
      if (!reset) begin
         m_h0 = 4'hF; m_h1 = 4'hF; m_tick = 0; m_col = 0; m_prun = 0; m_rrun = 0;
         m_cand = 4'hF; m_code = 4'h0; m_valid = 0; m_down = 0; m_int = 0;
      end else begin
         s   = m_h1;
         smp = ((m_tick % SD) == SD - 1);
         acc = 0;
         m_valid = 0;
         if (smp) begin
            if (m_down) begin
               if (s == 4'hF) begin
                  m_rrun++;
                  if (m_rrun == DC) begin m_down = 0; m_rrun = 0; m_col = (m_col + 1) % 4; end
               end else m_rrun = 0;
            end else if (m_prun == 0) begin
               if (s == 4'hF) m_col = (m_col + 1) % 4;
               else begin m_cand = s; m_prun = 1; end
            end else if (s == m_cand) begin
               m_prun++;
               if (m_prun == DC) begin
                  acc = 1; m_prun = 0; m_down = 1; m_valid = 1;
                  m_code = 4'(low_zero(m_cand) * 4 + m_col);
               end
            end else begin
               m_prun = 0; m_col = (m_col + 1) % 4;
            end
         end
         if (acc) m_int = 1;
         else if (int_ack) m_int = 0;
         m_h1 = m_h0;
         m_h0 = row;
         m_tick++;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         exp_col = ~(4'b0001 << m_col);
         chk("cyc_column", column, exp_col);
         chk("cyc_key_code", key_code, m_code);
         chk("cyc_key_valid", key_valid, m_valid);
         chk("cyc_key_down", key_down, m_down);
         chk("cyc_interrupt", interrupt, m_int);
      end
   end

   task automatic wait_valid(input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (key_valid) begin ok = 1; break; end
      end
   endtask

   task automatic wait_up(input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!key_down) begin ok = 1; break; end
      end
   endtask

   task automatic count_valid(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (key_valid) n++;
      end
   endtask

   initial begin
      bit ok;
      int nv, mode, hold;
      logic [3:0] ecol;
      reset = 1'b0; keys = '0; glitch = '0; int_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("rst_column", column, 4'b1110);
      chk("rst_outputs", {key_code, key_valid, key_down, interrupt}, 7'd0);

      // free-running scan
      reset = 1'b1;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         ecol = ~(4'b0001 << (((j + 1) / 4) % 4));
         chk("scan_column", column, ecol);
      end

      // clean press of key 9 (row 2, column 1) and release
      keys = 16'(1) << 9;
      wait_valid(200, ok);
      chk("press_timeout", ok, 1);
      chk("press_code", key_code, 9);
      chk("press_down", key_down, 1);
      chk("press_int", interrupt, 1);
      @(negedge clk);
      chk("valid_one_cycle", key_valid, 0);
      keys = '0;
      wait_up(200, ok);
      chk("release_timeout", ok, 1);
      chk("release_column", column, 4'b1011);

      // single-sample bounce
      @(negedge clk);
      glitch = 4'b0010;
      repeat (SD) @(negedge clk);
      glitch = 4'b0000;
      count_valid(30, nv);
      chk("bounce_no_valid", nv, 0);
      chk("bounce_not_down", key_down, 0);

      // two rows in column 3, then release the row 0 key only
      keys = (16'(1) << 3) | (16'(1) << 11);
      wait_valid(200, ok);
      chk("samecol_timeout", ok, 1);
      chk("samecol_code", key_code, 3);
      keys = 16'(1) << 11;
      count_valid(40, nv);
      chk("samecol_no_valid", nv, 0);
      chk("samecol_still_down", key_down, 1);
      keys = '0;
      wait_up(200, ok);
      chk("samecol_rel_timeout", ok, 1);

      // interrupt acknowledge, then acknowledge colliding with a new press
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
      @(negedge clk);
      chk("ack_clears", interrupt, 0);
      int_ack = 1'b1;
      keys = 16'(1) << 0;
      wait_valid(200, ok);
      chk("ackset_timeout", ok, 1);
      chk("ackset_int", interrupt, 1);
      int_ack = 1'b0;
      keys = '0;
      wait_up(200, ok);
      chk("ackset_rel_timeout", ok, 1);

      // reset during debounce
      keys = 16'(1) << 6;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_prun == 2) begin ok = 1; break; end
      end
      chk("mid_reach_debounce", ok, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_column", column, 4'b1110);
      chk("mid_rst_outputs", {key_code, key_valid, key_down, interrupt}, 7'd0);
      keys = '0;
      reset = 1'b1;
      count_valid(40, nv);
      chk("mid_rst_no_valid", nv, 0);

      // randomized traffic checked by the model every cycle
      for (int it = 0; it < 250; it++) begin
         mode = $urandom % 16;
         hold = $urandom_range(60, 1);
         glitch = '0;
         if (mode < 3) keys = '0;
         else if (mode < 10) keys = 16'(1) << ($urandom % 16);
         else if (mode < 13) keys = (16'(1) << ($urandom % 16)) | (16'(1) << ($urandom % 16));
         else if (mode < 15) begin keys = '0; glitch = 4'($urandom_range(15, 1)); hold = $urandom_range(8, 1); end
         else begin keys = '0; reset = 1'b0; hold = $urandom_range(2, 1); end
         for (int c = 0; c < hold; c++) begin
            int_ack = (($urandom % 12) == 0);
            @(negedge clk);
         end
         reset = 1'b1;
         int_ack = 1'b0;
      end
      keys = '0; glitch = '0;
      repeat (100) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
